uart_tx: RTL

Byte-wide UART transmitter that serialises one 8-bit word per request onto `uart_txd` as 8N1, with optional parity, at a fixed baud rate derived from the system clock. It is the transmit half of the UART link. It drives the serial line for the loopback design. In benches it replaces hand-timed `#8680` stimulus with a cycle-exact frame generator.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_baud_cnt.sv | 40 ++++
 rtl/uart_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - uart_state_e : frame FSM state encoding.
//   - PAR_*        : parity-mode constants for the PARITY parameter.
//   - baud_cnt_max : clock cycles per serial bit.
//   - cnt_width    : width of a counter that must hold 0..cnt_max-1.
//   - parity_bit   : parity bit for one data byte in a given mode.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Cycles per bit; integer division truncates, as the link expects.
    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    // $clog2 of the bit period, kept at least one bit wide.
    function automatic int cnt_width(input int cnt_max);
        return (cnt_max > 1) ? $clog2(cnt_max) : 1;
    endfunction

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic p;
        case (mode)
            PAR_ODD:  p = ~(^data);
            PAR_EVEN: p = ^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter shared by the UART transmitter and receiver.
// Ports:
//   sys_clk   in  : system clock
//   sys_rst_n in  : asynchronous active-low reset
//   run       in  : count while high, held at zero while low
//   cnt       out : current position inside the bit, 0..CNT_MAX-1
//   bit_end   out : one-cycle strobe on the last cycle of each bit
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CNT_MAX = 434,
    parameter int CNT_W   = cnt_width(CNT_MAX)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic             bit_end
);

    logic [CNT_W-1:0] cnt_r;
    logic             bit_end_s;

    assign bit_end_s = run && (cnt_r == CNT_W'(CNT_MAX - 1));

    // Counter: wraps at the end of each bit, clears whenever run is low.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_r <= '0;
        end else if (!run || bit_end_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign cnt     = cnt_r;
    assign bit_end = bit_end_s;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide 8N1 UART transmitter with optional parity bit.
// Frame on the line: start (0), D0..D7 LSB first, [parity], stop (1).
// Ports:
//   sys_clk      in  : system clock
//   sys_rst_n    in  : asynchronous active-low reset
//   uart_tx_en   in  : request strobe, sampled only while not busy
//   uart_tx_data in  : byte to send, latched on acceptance
//   uart_tx_busy out : high from the cycle after acceptance to the end of stop
//   uart_tx_done out : one-cycle pulse on the last stop-bit cycle
//   uart_txd     out : registered serial output, idle high
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int PARITY   = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_tx_en,
    input  logic [7:0] uart_tx_data,
    output logic       uart_tx_busy,
    output logic       uart_tx_done,
    output logic       uart_txd
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int CNT_W        = cnt_width(BAUD_CNT_MAX);

    uart_state_e      state_r;
    logic [7:0]       data_r;
    logic [2:0]       bit_idx_r;
    logic             txd_r;

    logic             run_s;
    logic             bit_end_s;
    logic [CNT_W-1:0] baud_cnt_s;
    logic             last_cycle_s;
    logic             busy_s;
    logic             accept_s;

    assign run_s = (state_r != ST_IDLE);

    uart_baud_cnt #(
        .CNT_MAX (BAUD_CNT_MAX),
        .CNT_W   (CNT_W)
    ) u_baud_cnt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .run       (run_s),
        .cnt       (baud_cnt_s),
        .bit_end   (bit_end_s)
    );

    // Busy falls in the final stop-bit cycle so a new request can be taken
    // there and the next start bit follows with no idle gap.
    assign last_cycle_s = (state_r == ST_STOP) && (baud_cnt_s == CNT_W'(BAUD_CNT_MAX - 1));
    assign busy_s       = run_s && !last_cycle_s;
    assign accept_s     = uart_tx_en && !busy_s;

    // Frame FSM; uart_txd is loaded with the level of the bit being entered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r   <= ST_IDLE;
            data_r    <= 8'h00;
            bit_idx_r <= 3'd0;
            txd_r     <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r   <= ST_START;
                        data_r    <= uart_tx_data;
                        bit_idx_r <= 3'd0;
                        txd_r     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r <= ST_DATA;
                        txd_r   <= data_r[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        if (bit_idx_r == 3'd7) begin
                            if (PARITY != PAR_NONE) begin
                                state_r <= ST_PAR;
                                txd_r   <= parity_bit(data_r, PARITY);
                            end else begin
                                state_r <= ST_STOP;
                                txd_r   <= 1'b1;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            txd_r     <= data_r[bit_idx_r + 3'd1];
                        end
                    end
                end
                ST_PAR: begin
                    if (bit_end_s) begin
                        state_r <= ST_STOP;
                        txd_r   <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (last_cycle_s) begin
                        if (accept_s) begin
                            state_r   <= ST_START;
                            data_r    <= uart_tx_data;
                            bit_idx_r <= 3'd0;
                            txd_r     <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            txd_r   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    txd_r   <= 1'b1;
                end
            endcase
        end
    end

    assign uart_txd     = txd_r;
    assign uart_tx_busy = busy_s;
    assign uart_tx_done = last_cycle_s;

endmodule
